// File: rtl/main_mem_arb.sv
// NES system/cartridge memory arbiter: decodes the logical address space into
// internal CPU-RAM/VRAM/open-bus and a shared req/ack cartridge backend.
module main_mem_arb #(
    parameter int         ADDR_W    = 22,
    parameter int         CPURAM_AW = 11,
    parameter int         VRAM_AW   = 11,
    parameter logic [7:0] OPEN_BUS  = 8'hFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_valid,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_rd,
    output logic [7:0]        ppu_q,
    output logic              ppu_valid,
    input  logic              rom_wp,
    input  logic              cart_ready,
    output logic              cart_req,
    output logic              cart_we,
    output logic [1:0]        cart_sel,
    output logic [20:0]       cart_addr,
    output logic [7:0]        cart_d,
    input  logic              cart_ack,
    input  logic [7:0]        cart_q,
    output logic              err
);

    // K_NULL covers open bus and write-protected ROM writes: no storage touched.
    typedef enum logic [1:0] {K_CART = 2'd0, K_VRAM = 2'd1, K_CRAM = 2'd2, K_NULL = 2'd3} kind_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DONE = 2'd2} cart_st_e;

    function automatic kind_e fn_kind(input logic [3:0] top);
        kind_e k;
        casez (top)
            4'b0???, 4'b10??, 4'b1111: k = K_CART;
            4'b1100:                   k = K_VRAM;
            4'b1110:                   k = K_CRAM;
            default:                   k = K_NULL;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] fn_sel(input logic [3:0] top);
        logic [1:0] s;
        casez (top)
            4'b0???: s = 2'd0;
            4'b10??: s = 2'd1;
            default: s = 2'd2;
        endcase
        return s;
    endfunction

    function automatic logic [20:0] fn_seg(input logic [ADDR_W-1:0] a);
        logic [20:0] s;
        casez (a[ADDR_W-1 -: 4])
            4'b0???: s = a[20:0];
            4'b10??: s = {1'b0, a[19:0]};
            default: s = {3'b000, a[17:0]};
        endcase
        return s;
    endfunction

    logic [7:0] cram_mem [0:(1<<CPURAM_AW)-1];
    logic [7:0] vram_mem [0:(1<<VRAM_AW)-1];
    logic [7:0] cram_rdata_q, vram_rdata_q;

    logic              cpu_vld_q, cpu_vld_d, cpu_wr_q, cpu_wr_d;
    kind_e             cpu_kind_q, cpu_kind_d, cpu_kind_s, cpu_kind_raw_s;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]        cpu_wdata_q, cpu_wdata_d;
    logic              ppu_vld_q, ppu_vld_d;
    kind_e             ppu_kind_q, ppu_kind_d;
    logic [ADDR_W-1:0] ppu_addr_q, ppu_addr_d;
    logic              err_q, err_d;

    logic       cpu_stg_vld_q, cpu_stg_vld_d, cpu_stg_rd_q, cpu_stg_rd_d;
    kind_e      cpu_stg_kind_q, cpu_stg_kind_d;
    logic       ppu_stg_vld_q, ppu_stg_vld_d;
    kind_e      ppu_stg_kind_q, ppu_stg_kind_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;
    logic       cpu_valid_q, cpu_valid_d, ppu_valid_q, ppu_valid_d;

    cart_st_e    state_q, state_d;
    logic        owner_ppu_q, owner_ppu_d;
    logic        cart_req_q, cart_req_d, cart_we_q, cart_we_d;
    logic [1:0]  cart_sel_q, cart_sel_d;
    logic [20:0] cart_addr_q, cart_addr_d;
    logic [7:0]  cart_d_q, cart_d_d;

    logic cpu_req_s, cpu_int_go_s, ppu_int_go_s;
    logic cpu_cart_ack_s, ppu_cart_ack_s, cpu_cart_free_s, ppu_cart_free_s;
    logic [VRAM_AW-1:0]   vram_idx_s;
    logic [CPURAM_AW-1:0] cram_idx_s;

    assign cpu_req_s      = cpu_rd | cpu_wr;
    assign cpu_kind_raw_s = fn_kind(cpu_addr[ADDR_W-1 -: 4]);

    // Region classification of an incoming CPU request, folding in write protect.
    always_comb begin
        if (cpu_wr && rom_wp && (cpu_kind_raw_s == K_CART) &&
            (fn_sel(cpu_addr[ADDR_W-1 -: 4]) != 2'd2)) begin
            cpu_kind_s = K_NULL;
        end else begin
            cpu_kind_s = cpu_kind_raw_s;
        end
    end

    // PPU always wins a same-RAM conflict; open bus never conflicts.
    assign ppu_int_go_s = ppu_vld_q && (ppu_kind_q != K_CART);
    assign cpu_int_go_s = cpu_vld_q && (cpu_kind_q != K_CART) &&
                          !(ppu_int_go_s && (ppu_kind_q == cpu_kind_q) && (cpu_kind_q != K_NULL));

    assign vram_idx_s = (ppu_int_go_s && (ppu_kind_q == K_VRAM)) ? ppu_addr_q[VRAM_AW-1:0]
                                                                 : cpu_addr_q[VRAM_AW-1:0];
    assign cram_idx_s = (ppu_int_go_s && (ppu_kind_q == K_CRAM)) ? ppu_addr_q[CPURAM_AW-1:0]
                                                                 : cpu_addr_q[CPURAM_AW-1:0];

    // Single-port internal RAMs: CPU writes, synchronous read for whichever port is served.
    always_ff @(posedge clock) begin
        if (cpu_int_go_s && cpu_wr_q && (cpu_kind_q == K_VRAM)) begin
            vram_mem[vram_idx_s] <= cpu_wdata_q;
        end
        if (cpu_int_go_s && cpu_wr_q && (cpu_kind_q == K_CRAM)) begin
            cram_mem[cram_idx_s] <= cpu_wdata_q;
        end
        vram_rdata_q <= vram_mem[vram_idx_s];
        cram_rdata_q <= cram_mem[cram_idx_s];
    end

    // Request slots: capture into an empty slot, flag overflow, free on service.
    always_comb begin
        cpu_vld_d   = cpu_vld_q;
        cpu_wr_d    = cpu_wr_q;
        cpu_kind_d  = cpu_kind_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        ppu_vld_d   = ppu_vld_q;
        ppu_kind_d  = ppu_kind_q;
        ppu_addr_d  = ppu_addr_q;
        err_d       = err_q;
        if (cpu_req_s && !cpu_vld_q) begin
            cpu_vld_d   = 1'b1;
            cpu_wr_d    = cpu_wr;
            cpu_kind_d  = cpu_kind_s;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_d;
        end else if (cpu_int_go_s || cpu_cart_free_s) begin
            cpu_vld_d = 1'b0;
        end else begin
            cpu_vld_d = cpu_vld_q;
        end
        if (ppu_rd && !ppu_vld_q) begin
            ppu_vld_d  = 1'b1;
            ppu_kind_d = fn_kind(ppu_addr[ADDR_W-1 -: 4]);
            ppu_addr_d = ppu_addr;
        end else if (ppu_int_go_s || ppu_cart_free_s) begin
            ppu_vld_d = 1'b0;
        end else begin
            ppu_vld_d = ppu_vld_q;
        end
        if ((cpu_req_s && cpu_vld_q) || (ppu_rd && ppu_vld_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Internal access stage and registered completion (q/valid) for both ports.
    always_comb begin
        cpu_stg_vld_d  = cpu_int_go_s;
        cpu_stg_rd_d   = !cpu_wr_q;
        cpu_stg_kind_d = cpu_kind_q;
        ppu_stg_vld_d  = ppu_int_go_s;
        ppu_stg_kind_d = ppu_kind_q;
        cpu_valid_d    = cpu_stg_vld_q | cpu_cart_ack_s;
        ppu_valid_d    = ppu_stg_vld_q | ppu_cart_ack_s;
        cpu_rdata_d    = cpu_rdata_q;
        ppu_rdata_d    = ppu_rdata_q;
        if (cpu_stg_vld_q && cpu_stg_rd_q) begin
            cpu_rdata_d = (cpu_stg_kind_q == K_VRAM) ? vram_rdata_q :
                          (cpu_stg_kind_q == K_CRAM) ? cram_rdata_q : OPEN_BUS;
        end else if (cpu_cart_ack_s && !cart_we_q) begin
            cpu_rdata_d = cart_q;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (ppu_stg_vld_q) begin
            ppu_rdata_d = (ppu_stg_kind_q == K_VRAM) ? vram_rdata_q :
                          (ppu_stg_kind_q == K_CRAM) ? cram_rdata_q : OPEN_BUS;
        end else if (ppu_cart_ack_s) begin
            ppu_rdata_d = cart_q;
        end else begin
            ppu_rdata_d = ppu_rdata_q;
        end
    end

    // Cart FSM next state and registered backend outputs; PPU has issue priority.
    always_comb begin
        state_d         = state_q;
        owner_ppu_d     = owner_ppu_q;
        cart_req_d      = cart_req_q;
        cart_we_d       = cart_we_q;
        cart_sel_d      = cart_sel_q;
        cart_addr_d     = cart_addr_q;
        cart_d_d        = cart_d_q;
        cpu_cart_ack_s  = 1'b0;
        ppu_cart_ack_s  = 1'b0;
        cpu_cart_free_s = 1'b0;
        ppu_cart_free_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cart_ready && ppu_vld_q && (ppu_kind_q == K_CART)) begin
                    state_d     = ST_ISSUE;
                    owner_ppu_d = 1'b1;
                    cart_req_d  = 1'b1;
                    cart_we_d   = 1'b0;
                    cart_sel_d  = fn_sel(ppu_addr_q[ADDR_W-1 -: 4]);
                    cart_addr_d = fn_seg(ppu_addr_q);
                    cart_d_d    = 8'h00;
                end else if (cart_ready && cpu_vld_q && (cpu_kind_q == K_CART)) begin
                    state_d     = ST_ISSUE;
                    owner_ppu_d = 1'b0;
                    cart_req_d  = 1'b1;
                    cart_we_d   = cpu_wr_q;
                    cart_sel_d  = fn_sel(cpu_addr_q[ADDR_W-1 -: 4]);
                    cart_addr_d = fn_seg(cpu_addr_q);
                    cart_d_d    = cpu_wdata_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cart_ack) begin
                    state_d        = ST_DONE;
                    cart_req_d     = 1'b0;
                    ppu_cart_ack_s = owner_ppu_q;
                    cpu_cart_ack_s = !owner_ppu_q;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d         = ST_IDLE;
                ppu_cart_free_s = owner_ppu_q;
                cpu_cart_free_s = !owner_ppu_q;
            end
            default: begin
                state_d    = ST_IDLE;
                cart_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cpu_vld_q      <= 1'b0;
            cpu_wr_q       <= 1'b0;
            cpu_kind_q     <= K_NULL;
            cpu_addr_q     <= '0;
            cpu_wdata_q    <= 8'h00;
            ppu_vld_q      <= 1'b0;
            ppu_kind_q     <= K_NULL;
            ppu_addr_q     <= '0;
            err_q          <= 1'b0;
            cpu_stg_vld_q  <= 1'b0;
            cpu_stg_rd_q   <= 1'b0;
            cpu_stg_kind_q <= K_NULL;
            ppu_stg_vld_q  <= 1'b0;
            ppu_stg_kind_q <= K_NULL;
            cpu_rdata_q    <= 8'h00;
            ppu_rdata_q    <= 8'h00;
            cpu_valid_q    <= 1'b0;
            ppu_valid_q    <= 1'b0;
            state_q        <= ST_IDLE;
            owner_ppu_q    <= 1'b0;
            cart_req_q     <= 1'b0;
            cart_we_q      <= 1'b0;
            cart_sel_q     <= 2'd0;
            cart_addr_q    <= 21'd0;
            cart_d_q       <= 8'h00;
        end else begin
            cpu_vld_q      <= cpu_vld_d;
            cpu_wr_q       <= cpu_wr_d;
            cpu_kind_q     <= cpu_kind_d;
            cpu_addr_q     <= cpu_addr_d;
            cpu_wdata_q    <= cpu_wdata_d;
            ppu_vld_q      <= ppu_vld_d;
            ppu_kind_q     <= ppu_kind_d;
            ppu_addr_q     <= ppu_addr_d;
            err_q          <= err_d;
            cpu_stg_vld_q  <= cpu_stg_vld_d;
            cpu_stg_rd_q   <= cpu_stg_rd_d;
            cpu_stg_kind_q <= cpu_stg_kind_d;
            ppu_stg_vld_q  <= ppu_stg_vld_d;
            ppu_stg_kind_q <= ppu_stg_kind_d;
            cpu_rdata_q    <= cpu_rdata_d;
            ppu_rdata_q    <= ppu_rdata_d;
            cpu_valid_q    <= cpu_valid_d;
            ppu_valid_q    <= ppu_valid_d;
            state_q        <= state_d;
            owner_ppu_q    <= owner_ppu_d;
            cart_req_q     <= cart_req_d;
            cart_we_q      <= cart_we_d;
            cart_sel_q     <= cart_sel_d;
            cart_addr_q    <= cart_addr_d;
            cart_d_q       <= cart_d_d;
        end
    end

    assign cpu_q     = cpu_rdata_q;
    assign cpu_valid = cpu_valid_q;
    assign ppu_q     = ppu_rdata_q;
    assign ppu_valid = ppu_valid_q;
    assign cart_req  = cart_req_q;
    assign cart_we   = cart_we_q;
    assign cart_sel  = cart_sel_q;
    assign cart_addr = cart_addr_q;
    assign cart_d    = cart_d_q;
    assign err       = err_q;

endmodule

// File: tb/tb_main_mem_arb.sv
// Bench for main_mem_arb: directed scenarios plus randomized traffic against
// a byte-array memory model and address-map arithmetic.
module tb_main_mem_arb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [21:0] cpu_addr, ppu_addr;
    logic        cpu_rd, cpu_wr, ppu_rd;
    logic [7:0]  cpu_d, cpu_q, ppu_q;
    logic        cpu_valid, ppu_valid;
    logic        rom_wp, cart_ready, cart_req, cart_we, cart_ack, err;
    logic [1:0]  cart_sel;
    logic [20:0] cart_addr;
    logic [7:0]  cart_d, cart_q;

    always #5 clock = ~clock;

    main_mem_arb dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_valid(cpu_valid),
        .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_q(ppu_q), .ppu_valid(ppu_valid),
        .rom_wp(rom_wp), .cart_ready(cart_ready), .cart_req(cart_req), .cart_we(cart_we),
        .cart_sel(cart_sel), .cart_addr(cart_addr), .cart_d(cart_d),
        .cart_ack(cart_ack), .cart_q(cart_q), .err(err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0]  m_cram [0:2047];
    logic [7:0]  m_vram [0:2047];
    logic [7:0]  exp_cpu_q = 8'h00;
    logic [7:0]  exp_ppu_q = 8'h00;
    logic [21:0] cram_pool [0:7];
    logic [21:0] vram_pool [0:7];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_read(input logic [21:0] a);
        int top = int'(a >> 18);
        if (top == 12) return m_vram[a % 2048];
        if (top == 14) return m_cram[a % 2048];
        return 8'hFF;
    endfunction

    function automatic logic [31:0] exp_sel(input logic [21:0] a);
        int top = int'(a >> 18);
        if (top < 8)  return 32'd0;
        if (top < 12) return 32'd1;
        return 32'd2;
    endfunction

    function automatic logic [31:0] exp_seg(input logic [21:0] a);
        int top = int'(a >> 18);
        if (top < 8)  return 32'(a % (1 << 21));
        if (top < 12) return 32'(a % (1 << 20));
        return 32'(a % (1 << 18));
    endfunction

    // Internal (non-cart) CPU access: valid two edges after capture, one cycle wide.
    task automatic cpu_int(input bit rd, input bit wr, input logic [21:0] a, input logic [7:0] d,
                           input string tag);
        int top = int'(a >> 18);
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_d = d;
        step();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        step();
        check({tag, "/valid_early"}, 32'(cpu_valid), 32'd0);
        if (wr) begin
            if (top == 12) m_vram[a % 2048] = d;
            else if (top == 14) m_cram[a % 2048] = d;
        end else begin
            exp_cpu_q = model_read(a);
        end
        step();
        check({tag, "/valid"}, 32'(cpu_valid), 32'd1);
        check({tag, "/q"}, 32'(cpu_q), 32'(exp_cpu_q));
        check({tag, "/no_req"}, 32'(cart_req), 32'd0);
        step();
        check({tag, "/valid_end"}, 32'(cpu_valid), 32'd0);
    endtask

    task automatic ppu_int(input logic [21:0] a, input string tag);
        ppu_addr = a; ppu_rd = 1'b1;
        step();
        ppu_rd = 1'b0;
        step();
        check({tag, "/valid_early"}, 32'(ppu_valid), 32'd0);
        exp_ppu_q = model_read(a);
        step();
        check({tag, "/valid"}, 32'(ppu_valid), 32'd1);
        check({tag, "/q"}, 32'(ppu_q), 32'(exp_ppu_q));
        step();
        check({tag, "/valid_end"}, 32'(ppu_valid), 32'd0);
    endtask

    // One cart transaction with a backend that acks lat cycles after issue.
    task automatic cart_txn(input bit is_ppu, input bit wr, input logic [21:0] a,
                            input logic [7:0] d, input int lat, input logic [7:0] data,
                            input string tag);
        if (is_ppu) begin
            ppu_addr = a; ppu_rd = 1'b1;
        end else begin
            cpu_addr = a; cpu_wr = wr; cpu_rd = !wr; cpu_d = d;
        end
        step();
        ppu_rd = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        step();
        check({tag, "/req"}, 32'(cart_req), 32'd1);
        check({tag, "/sel"}, 32'(cart_sel), exp_sel(a));
        check({tag, "/addr"}, 32'(cart_addr), exp_seg(a));
        check({tag, "/we"}, 32'(cart_we), 32'(wr));
        if (wr) check({tag, "/d"}, 32'(cart_d), 32'(d));
        repeat (lat) step();
        check({tag, "/req_held"}, 32'(cart_req), 32'd1);
        check({tag, "/no_valid"}, 32'(is_ppu ? ppu_valid : cpu_valid), 32'd0);
        cart_ack = 1'b1; cart_q = data;
        step();
        cart_ack = 1'b0;
        if (is_ppu) exp_ppu_q = data;
        else if (!wr) exp_cpu_q = data;
        check({tag, "/valid"}, 32'(is_ppu ? ppu_valid : cpu_valid), 32'd1);
        check({tag, "/q"}, 32'(is_ppu ? ppu_q : cpu_q), 32'(is_ppu ? exp_ppu_q : exp_cpu_q));
        check({tag, "/req_drop"}, 32'(cart_req), 32'd0);
        step();
        check({tag, "/valid_end"}, 32'(is_ppu ? ppu_valid : cpu_valid), 32'd0);
    endtask

    initial begin
        logic [21:0] a;
        logic [7:0]  d;
        reset_n = 1'b0; cpu_addr = 22'd0; ppu_addr = 22'd0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_d = 8'h00; ppu_rd = 1'b0; rom_wp = 1'b0; cart_ready = 1'b0; cart_ack = 1'b0;
        cart_q = 8'h00;
        step();
        step();
        check("rst/cpu_q", 32'(cpu_q), 32'd0);
        check("rst/ppu_q", 32'(ppu_q), 32'd0);
        check("rst/valids", 32'({cpu_valid, ppu_valid}), 32'd0);
        check("rst/cart", 32'({cart_req, cart_we, cart_sel, cart_addr, cart_d}), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        reset_n = 1'b1;
        step();

        cpu_int(1'b0, 1'b1, 22'h380005, 8'h5A, "ram_wr");
        cpu_int(1'b1, 1'b0, 22'h380005, 8'h00, "ram_rd");
        cpu_int(1'b1, 1'b1, 22'h380006, 8'hC3, "rdwr_is_wr");
        cpu_int(1'b1, 1'b0, 22'h380006, 8'h00, "rdwr_readback");

        cpu_int(1'b0, 1'b1, 22'h300010, 8'h77, "vram_wr");
        cpu_addr = 22'h300010; ppu_addr = 22'h300010; cpu_rd = 1'b1; ppu_rd = 1'b1;
        step();
        cpu_rd = 1'b0; ppu_rd = 1'b0;
        step();
        check("coll/e1", 32'({cpu_valid, ppu_valid}), 32'd0);
        step();
        check("coll/ppu_valid", 32'({cpu_valid, ppu_valid}), 32'b01);
        check("coll/ppu_q", 32'(ppu_q), 32'h77);
        step();
        check("coll/cpu_valid", 32'({cpu_valid, ppu_valid}), 32'b10);
        check("coll/cpu_q", 32'(cpu_q), 32'h77);
        step();
        check("coll/end", 32'({cpu_valid, ppu_valid}), 32'd0);
        exp_cpu_q = 8'h77; exp_ppu_q = 8'h77;

        for (int i = 0; i < 8; i++) begin
            cram_pool[i] = 22'h380000 + 22'($urandom_range(0, 2047));
            vram_pool[i] = 22'h300000 + 22'($urandom_range(0, 2047));
            cpu_int(1'b0, 1'b1, cram_pool[i], 8'($urandom), "fill_cram");
            cpu_int(1'b0, 1'b1, vram_pool[i], 8'($urandom), "fill_vram");
        end
        for (int i = 0; i < 30; i++) begin
            int k = int'($urandom_range(0, 7));
            d = 8'($urandom);
            case ($urandom_range(0, 5))
                0: cpu_int(1'b1, 1'b0, cram_pool[k], d, "rnd_cram_rd");
                1: cpu_int(1'b0, 1'b1, cram_pool[k], d, "rnd_cram_wr");
                2: cpu_int(1'b1, 1'b0, vram_pool[k], d, "rnd_vram_rd");
                3: cpu_int(1'b0, 1'b1, vram_pool[k], d, "rnd_vram_wr");
                4: ppu_int(($urandom_range(0, 1) == 0) ? vram_pool[k] : cram_pool[k], "rnd_ppu_rd");
                default: cpu_int(1'b1, 1'b0, 22'h340000 + 22'($urandom_range(0, 262143)), d, "rnd_open");
            endcase
        end

        cart_ready = 1'b1;
        cart_txn(1'b1, 1'b0, 22'h200100, 8'h00, 5, 8'h3C, "cart_hs");

        cart_ready = 1'b0;
        cpu_addr = 22'h000010; cpu_rd = 1'b1; ppu_addr = 22'h200000; ppu_rd = 1'b1;
        step();
        cpu_rd = 1'b0; ppu_rd = 1'b0;
        step();
        step();
        step();
        check("gate/no_req", 32'(cart_req), 32'd0);
        cart_ready = 1'b1;
        step();
        check("prio/ppu_req", 32'({cart_req, cart_sel}), 32'b101);
        check("prio/ppu_addr", 32'(cart_addr), 32'h0);
        cart_ack = 1'b1; cart_q = 8'hA1;
        step();
        cart_ack = 1'b0;
        check("prio/ppu_valid", 32'(ppu_valid), 32'd1);
        check("prio/ppu_q", 32'(ppu_q), 32'hA1);
        step();
        check("prio/done_idle", 32'({cart_req, ppu_valid, cpu_valid}), 32'd0);
        step();
        check("prio/cpu_req", 32'({cart_req, cart_sel}), 32'b100);
        check("prio/cpu_addr", 32'(cart_addr), 32'h10);
        cart_ack = 1'b1; cart_q = 8'hB2;
        step();
        cart_ack = 1'b0;
        check("prio/cpu_valid", 32'(cpu_valid), 32'd1);
        check("prio/cpu_q", 32'(cpu_q), 32'hB2);
        exp_cpu_q = 8'hB2; exp_ppu_q = 8'hA1;
        step();

        for (int i = 0; i < 8; i++) begin
            int r = int'($urandom_range(0, 2));
            bit is_ppu = ($urandom_range(0, 1) == 1);
            bit wr = !is_ppu && ($urandom_range(0, 1) == 1);
            a = (r == 0) ? 22'($urandom_range(0, 22'h1FFFFF)) :
                (r == 1) ? 22'h200000 + 22'($urandom_range(0, 22'hFFFFF)) :
                           22'h3C0000 + 22'($urandom_range(0, 22'h3FFFF));
            cart_txn(is_ppu, wr, a, 8'($urandom), int'($urandom_range(0, 4)), 8'($urandom), "rnd_cart");
        end

        rom_wp = 1'b1;
        cpu_int(1'b0, 1'b1, 22'h001234, 8'h99, "wp_prg");
        cpu_int(1'b1, 1'b0, 22'h340000, 8'h00, "open_bus");
        rom_wp = 1'b0;

        cpu_addr = 22'h000020; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        step();
        check("ovf/issue", 32'({cart_req, err}), 32'b10);
        cpu_addr = 22'h380000; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        check("ovf/err", 32'(err), 32'd1);
        step();
        check("ovf/sticky", 32'({cart_req, err}), 32'b11);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("ovf/rst_req", 32'(cart_req), 32'd0);
        check("ovf/rst_err", 32'(err), 32'd0);
        check("ovf/rst_q", 32'(cpu_q), 32'd0);
        cart_ack = 1'b1; cart_q = 8'h55;
        step();
        cart_ack = 1'b0;
        check("late_ack/valid", 32'({cpu_valid, ppu_valid}), 32'd0);
        check("late_ack/q", 32'(cpu_q), 32'd0);
        step();
        check("late_ack/after", 32'({cpu_valid, ppu_valid, cart_req}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/main_mem_arb.md
Name: main_mem_arb

Overview:
- Parametrised successor to the NES system/cartridge memory block.
- Decodes the 22-bit NES logical address space into internal CPU-RAM, internal VRAM, open-bus, and an external cartridge backend (PRG/CHR/cart-RAM).
- Gives the CPU and PPU independent request slots, each with a registered read-data and valid strobe.
- Arbitrates the shared cartridge backend with a req/ack handshake, so backends with variable latency (SPRAM, flash cache) plug in unchanged.

Parameters:
- ADDR_W, 22: NES logical address width.
- CPURAM_AW, 11: internal CPU-RAM address bits (depth 2^CPURAM_AW bytes).
- VRAM_AW, 11: internal VRAM address bits (depth 2^VRAM_AW bytes); 12 gives four-screen VRAM.
- OPEN_BUS, 8'hFF: read data returned for unmapped region 1101.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cpu_addr  in  ADDR_W  CPU request address
- cpu_rd  in  1  CPU read request pulse
- cpu_wr  in  1  CPU write request pulse
- cpu_d  in  8  CPU write data
- cpu_q  out  8  CPU read data
- cpu_valid  out  1  one-cycle completion strobe for a CPU read or write
- ppu_addr  in  ADDR_W  PPU request address
- ppu_rd  in  1  PPU read request pulse (the PPU is read-only)
- ppu_q  out  8  PPU read data
- ppu_valid  out  1  one-cycle PPU completion strobe
- rom_wp  in  1  when high, writes to PRG/CHR are dropped
- cart_ready  in  1  backend loaded; gates issue of cart requests
- cart_req  out  1  backend request; held until acknowledged
- cart_we  out  1  backend write qualifier
- cart_sel  out  2  backend region: 0=PRG, 1=CHR, 2=cart-RAM
- cart_addr  out  21  backend segment address
- cart_d  out  8  backend write data
- cart_ack  in  1  backend completion; cart_q valid in the same cycle
- cart_q  in  8  backend read data
- err  out  1  sticky overflow flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge):
  - cpu_q, ppu_q, cpu_valid, ppu_valid, cart_req, cart_we, cart_sel, cart_addr, cart_d and err all go to 0.
  - Both slots are emptied and the cart FSM returns to IDLE.
  - An in-flight cart transaction is abandoned; a cart_ack arriving after reset is ignored.
- Address decode (top 4 bits):
  - 0xxx: PRG; segment address = addr[20:0].
  - 10xx: CHR; segment address = {0, addr[19:0]}.
  - 1100: VRAM; uses addr[VRAM_AW-1:0].
  - 1101: open bus.
  - 1110: CPU-RAM; uses addr[CPURAM_AW-1:0].
  - 1111: cart-RAM; segment address = {000, addr[17:0]}.
- Slots:
  - Each port has one pending slot holding address, region, op and data.
  - A request is captured at the edge where rd/wr is high and the slot is empty.
  - A request arriving while the slot is occupied is dropped and sets err.
  - If cpu_rd and cpu_wr are high together, it is treated as a write.
- Internal RAM and open bus:
  - Slot captured at edge E0, RAM accessed at E1, q and valid registered at E2. Valid is high for the cycle after E2, i.e. 2 cycles after the request.
  - CPU and PPU hitting the same internal RAM in the same cycle: PPU is served first and CPU one cycle later. Different RAMs are served in parallel.
  - Open bus returns OPEN_BUS with the same 2-cycle timing.
- Cart FSM states: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE when a slot holds a cart region and cart_ready=1. PPU has priority when both slots are pending.
  - The cart_* outputs are registered on entry to ISSUE. cart_req stays high in ISSUE until the edge where cart_ack=1.
  - At that edge, cart_q is captured into the owning port's q, and the FSM moves ISSUE -> DONE.
  - In DONE, the owner's valid is high for one cycle; the FSM then returns to IDLE and frees the slot.
  - With cart_ready=0, cart slots wait indefinitely and internal-RAM slots are unaffected.
- Writes:
  - A CPU write to PRG/CHR with rom_wp=1 is never issued; cpu_valid pulses 2 cycles after the request.
  - A write produces cpu_valid but leaves cpu_q unchanged.
- q holds its last value between completions.
- cpu_valid and ppu_valid are never high for more than one cycle per request.
- err clears only on reset.

Test Plan:
- Internal RAM write then read: cpu_wr to 0x380005 with 0x5A, then cpu_rd 0x380005 -> cpu_valid pulses for both; cpu_q=0x5A exactly 2 cycles after the read.
- RAM collision: same-cycle cpu_rd and ppu_rd to 0x300010 (VRAM holding 0x77) -> ppu_valid at +2 and cpu_valid at +3; both q=0x77.
- Cart handshake: with cart_ready=1, ppu_rd 0x200100 -> cart_req=1, cart_sel=1, cart_addr=0x000100; ack after 5 cycles with cart_q=0x3C -> ppu_valid one cycle after ack, ppu_q=0x3C.
- Priority and gating: with cart_ready=0, cpu_rd 0x000010 and ppu_rd 0x200000 -> no cart_req; raise cart_ready -> PPU issued first, CPU issued after PPU's DONE.
- Write-protect and open bus: rom_wp=1, cpu_wr 0x001234 -> no cart_req, cpu_valid at +2; cpu_rd 0x340000 -> cpu_q=0xFF.
- Overflow and reset: second cpu_rd while a cart read is pending -> err=1; assert reset_n=0 mid-ISSUE -> cart_req=0, err=0 next cycle; a late cart_ack produces no valid.
